wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
Writeback stage directly upstream of the register file; it owns the register file's single write port.
- Merges two result sources onto that port:
  - single-cycle ALU results from the main pipeline;
  - long-latency results (multiply/divide/load) arriving on a valid/ready handshake.
- Keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.
- Forces a pipeline stall when long-latency results are starved.

Parameters:
WIDTH, 32, data width; must match the register file.
REGBITS, 3, register address width; the block tracks 1<<REGBITS registers.
STARVE_MAX, 4, consecutive cycles the FIFO head may wait before alu_stall_o asserts (legal range 1..15).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_valid_i  in  1  ALU result present this cycle; cannot be back-pressured
alu_wa_i  in  REGBITS  ALU destination register
alu_wd_i  in  WIDTH  ALU result data
lu_valid_i  in  1  long-latency result valid
lu_ready_o  out  1  block can accept a long-latency result
lu_wa_i  in  REGBITS  long-latency destination register
lu_wd_i  in  WIDTH  long-latency result data
iss_valid_i  in  1  decode is issuing a long-latency op this cycle
iss_wa_i  in  REGBITS  destination register of the issued op
rf_we_o  out  1  register file write enable (registered)
rf_wa_o  out  REGBITS  register file write address (registered)
rf_wd_o  out  WIDTH  register file write data (registered); also serves as the bypass source
busy_o  out  1<<REGBITS  scoreboard; bit n set means register n has a long-latency write pending
alu_stall_o  out  1  registered; upstream must hold alu_valid_i=0 while it is high

Behaviour:
Reset (while rst=1, at each clk edge):
- rf_we_o=0, rf_wa_o=0, rf_wd_o=0.
- busy_o=0, alu_stall_o=0.
- FIFO empty; starve counter 0.
- lu_ready_o=0 combinationally while rst=1, regardless of FIFO state.
- Mid-operation reset discards all FIFO contents and pending busy bits.

LU FIFO (2 entries of {wa, wd}):
- lu_ready_o = !full, except forced 0 during reset.
- Push on lu_valid_i && lu_ready_o && lu_wa_i!=0.
- A handshake with lu_wa_i==0 completes (ready honoured) and the data is dropped.
- Pointer-based, wrap-around.
- When full, a push and a pop cannot coincide because ready is low. Push and pop in the same cycle are legal at 1 entry.

Arbitration (one decision per cycle; the winner is registered onto rf_* at the next edge):
- alu_stall_o=1 and FIFO non-empty: pop the FIFO head. alu_valid_i is ignored; a simulation assertion fires if it is high.
- Otherwise, alu_valid_i=1 and alu_wa_i!=0: write the ALU result.
- Otherwise, FIFO non-empty: pop the FIFO head.
- Otherwise: rf_we_o=0 next cycle; rf_wa_o/rf_wd_o hold their previous values.
- An ALU result with alu_wa_i==0 counts as no request, so the FIFO may pop that cycle.
- rf_we_o is never 1 with rf_wa_o==0.

Latency:
- ALU: result visible on rf_* 1 cycle after alu_valid_i.
- LU: result visible on rf_* no earlier than 2 cycles after the accepting edge (edge 1 pushes, edge 2 pops to rf_*).

Starvation:
- The counter increments each cycle the FIFO is non-empty and no pop occurs; it clears on any pop or when the FIFO is empty.
- alu_stall_o is set at the edge where the counter reaches STARVE_MAX.
- alu_stall_o clears at the edge at which the pop occurs.

Scoreboard:
- iss_valid_i && iss_wa_i!=0 sets busy[iss_wa_i].
- A FIFO pop clears busy[popped wa] at the same edge the value is registered onto rf_*.
- Set and clear of the same bit in the same cycle: set wins.
- Issuing to a register already busy is a protocol violation; decode prevents it and a simulation assertion checks it.
- An ALU write to a busy register is performed and busy_o is unchanged. Decode prevents this case too.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - WIDTH/REGBITS defaults;
  - the zero-register constant (CONST_ZERO);
  - the wb_req struct {valid, wa, wd} used by both sources.
- One natural sub-module: wb_fifo2, a generic 2-entry valid/ready FIFO holding {wa, wd} that exposes full/empty/head.
- Arbiter, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset: hold rst 3 cycles with lu_valid_i=1 → lu_ready_o=0, all outputs 0, nothing written after release.
- ALU path: alu_valid_i=1, wa=3, wd=0xDEADBEEF → next cycle rf_we_o=1, rf_wa_o=3, rf_wd_o=0xDEADBEEF. Then wa=0 → rf_we_o=0.
- LU path: iss wa=5 → busy_o[5]=1. LU result wa=5, wd=0x1234 with ALU idle → rf_* shows it 2 cycles after the handshake, and busy_o[5] clears on that same edge.
- Priority and full FIFO: with continuous ALU writes, push 2 LU results → lu_ready_o=0 while full; a third lu_valid_i holds until a pop.
- Starvation (STARVE_MAX=4): continuous ALU traffic with 1 FIFO entry → alu_stall_o=1 after 4 waiting cycles; the next write is the LU entry; alu_stall_o clears at the pop edge.
- Scoreboard race: pop for reg 2 and iss_wa_i=2 in the same cycle → busy_o[2] remains 1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: default widths, the zero register and the
// request record that both result sources present to the arbiter.
package wb_arbiter_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_REGBITS    = 3;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CONST_ZERO     = 0;

  typedef struct packed {
    logic                   valid;
    logic [DEF_REGBITS-1:0] wa;
    logic [DEF_WIDTH-1:0]   wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Generic 2-entry FIFO with wrap-around pointers; exposes full/empty and the
// head entry so the consumer can inspect it before popping.
module wb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the register-file write port: merges ALU and
// long-latency results, tracks pending destinations and stalls a starving ALU.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REGBITS    = DEF_REGBITS,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid_i,
  input  logic [REGBITS-1:0]      alu_wa_i,
  input  logic [WIDTH-1:0]        alu_wd_i,
  input  logic                    lu_valid_i,
  output logic                    lu_ready_o,
  input  logic [REGBITS-1:0]      lu_wa_i,
  input  logic [WIDTH-1:0]        lu_wd_i,
  input  logic                    iss_valid_i,
  input  logic [REGBITS-1:0]      iss_wa_i,
  output logic                    rf_we_o,
  output logic [REGBITS-1:0]      rf_wa_o,
  output logic [WIDTH-1:0]        rf_wd_o,
  output logic [(1<<REGBITS)-1:0] busy_o,
  output logic                    alu_stall_o
);

  localparam int                 NREGS     = 1 << REGBITS;
  localparam int                 FW        = REGBITS + WIDTH;
  localparam logic [REGBITS-1:0] ZERO_WA   = REGBITS'(CONST_ZERO);
  localparam logic [3:0]         STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic               valid;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
  } req_t;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic             push;
  logic             pop;
  req_t             alu_req;
  req_t             lu_req;
  req_t             win;

  logic             rf_we_q;
  logic [REGBITS-1:0] rf_wa_q;
  logic [WIDTH-1:0] rf_wd_q;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [3:0]       starve_q, starve_d;
  logic             stall_q, stall_d;

  // LU handshake: a transfer happens on any edge where lu_valid_i and
  // lu_ready_o are both high; results for register 0 complete but are dropped.
  assign lu_ready_o = !rst && !fifo_full;
  assign push       = lu_valid_i && lu_ready_o && (lu_wa_i != ZERO_WA);

  wb_fifo2 #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({lu_wa_i, lu_wd_i}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    alu_req = '{valid: alu_valid_i && (alu_wa_i != ZERO_WA), wa: alu_wa_i, wd: alu_wd_i};
    lu_req  = '{valid: !fifo_empty, wa: fifo_head[FW-1:WIDTH], wd: fifo_head[WIDTH-1:0]};
    // A raised stall hands the slot to the FIFO head regardless of the ALU.
    pop     = lu_req.valid && (stall_q || !alu_req.valid);
    win     = pop ? lu_req : alu_req;
  end

  always_comb begin
    starve_d = '0;
    stall_d  = stall_q;
    if (pop) begin
      stall_d = 1'b0;
    end else if (!fifo_empty) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
      if (starve_d == STARVE_LIM) stall_d = 1'b1;
    end
  end

  // Clear first so a same-cycle issue to the popped register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[win.wa] = 1'b0;
    if (iss_valid_i && (iss_wa_i != ZERO_WA)) busy_d[iss_wa_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rf_we_q <= win.valid;
      if (win.valid) begin
        rf_wa_q <= win.wa;
        rf_wd_q <= win.wd;
      end
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_wa_o     = rf_wa_q;
  assign rf_wd_o     = rf_wd_q;
  assign busy_o      = busy_q;
  assign alu_stall_o = stall_q;

  a_no_alu_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(stall_q && alu_valid_i));

  a_no_issue_to_busy: assert property (@(posedge clk) disable iff (rst)
    !(iss_valid_i && (iss_wa_i != ZERO_WA) && busy_q[iss_wa_i] &&
      !(pop && (lu_req.wa == iss_wa_i))));

endmodule
